// File: rtl/operand_fetch_wb.sv
// Operand-fetch / writeback stage for an 8-bit execute adder.
// It decodes ADD, LI, JUMP and NOP. Operands are registered one cycle ahead of
// the combinational execute stage. The returned sum (alu_out) is written back
// into a 4-entry register file on the following edge. A pending writeback is
// bypassed to the next instruction's operands.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   instr        [7:6] opcode, [5:4] rd, [3:2] rs, [3:0] imm4, [5:0] target6
//   instr_valid  instr is consumed at the next rising edge
//   alu_out      combinational sum returned from the execute stage
//   alu_input_a  registered operand A
//   alu_input_b  registered operand B
//   wb_pending   alu_out is written to R[wb_rd] at the next edge
//   wb_rd        destination of the pending writeback
//   jump_valid   one-cycle pulse on JUMP
//   jump_target  last jump address, held until the next JUMP
//   dbg_addr     debug read address
//   dbg_data     R[dbg_addr], register array only (no bypass)
module operand_fetch_wb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_N  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] alu_input_a,
  output logic [DATA_W-1:0] alu_input_b,
  output logic              wb_pending,
  output logic [1:0]        wb_rd,
  output logic              jump_valid,
  output logic [5:0]        jump_target,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpLi   = 2'b01,
    OpJump = 2'b10,
    OpNop  = 2'b11
  } opcode_e;

  opcode_e     opcode;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [3:0]  imm4;
  logic [5:0]  target6;

  assign opcode  = opcode_e'(instr[7:6]);
  assign rd      = instr[5:4];
  assign rs      = instr[3:2];
  assign imm4    = instr[3:0];
  assign target6 = instr[5:0];

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              wbp_q, wbp_d;
  logic [1:0]        wbrd_q, wbrd_d;
  logic              jv_q, jv_d;
  logic [5:0]        jt_q, jt_d;
  logic [DATA_W-1:0] src_rd;
  logic [DATA_W-1:0] src_rs;

  // The value being written this edge is not yet in regs_q, so forward it.
  assign src_rd = (wbp_q && (wbrd_q == rd)) ? alu_out : regs_q[rd];
  assign src_rs = (wbp_q && (wbrd_q == rs)) ? alu_out : regs_q[rs];

  always_comb begin
    a_d    = '0;
    b_d    = '0;
    wbp_d  = 1'b0;
    wbrd_d = wbrd_q;
    jv_d   = 1'b0;
    jt_d   = jt_q;
    if (instr_valid) begin
      unique case (opcode)
        OpAdd: begin
          a_d    = src_rd;
          b_d    = src_rs;
          wbp_d  = 1'b1;
          wbrd_d = rd;
        end
        OpLi: begin
          a_d    = DATA_W'(imm4);
          wbp_d  = 1'b1;
          wbrd_d = rd;
        end
        OpJump: begin
          jv_d = 1'b1;
          jt_d = target6;
        end
        OpNop: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      wbp_q  <= 1'b0;
      wbrd_q <= '0;
      jv_q   <= 1'b0;
      jt_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      wbp_q  <= wbp_d;
      wbrd_q <= wbrd_d;
      jv_q   <= jv_d;
      jt_q   <= jt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_N); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wbp_q) begin
      regs_q[wbrd_q] <= alu_out;
    end
  end

  assign alu_input_a = a_q;
  assign alu_input_b = b_q;
  assign wb_pending  = wbp_q;
  assign wb_rd       = wbrd_q;
  assign jump_valid  = jv_q;
  assign jump_target = jt_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_operand_fetch_wb.sv
// Scoreboard bench for operand_fetch_wb. The execute adder is modelled here as
// alu_out = a + b (mod 256). Each stimulus cycle pushes the hand-computed state
// expected after its edge; a monitor pops and compares just after every edge.
module tb_operand_fetch_wb;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] alu_out;
  logic [7:0] alu_input_a;
  logic [7:0] alu_input_b;
  logic       wb_pending;
  logic [1:0] wb_rd;
  logic       jump_valid;
  logic [5:0] jump_target;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  assign alu_out = alu_input_a + alu_input_b;

  operand_fetch_wb #(.DATA_W(8), .REG_N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .alu_out     (alu_out),
    .alu_input_a (alu_input_a),
    .alu_input_b (alu_input_b),
    .wb_pending  (wb_pending),
    .wb_rd       (wb_rd),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       wbp;
    logic [1:0] rd;
    logic       jv;
    logic [5:0] jt;
    logic [1:0] dba;
    logic [7:0] dbg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: the DUT presents a new state after every edge.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".a"}, 32'(alu_input_a), 32'(e.a));
      chk({e.name, ".b"}, 32'(alu_input_b), 32'(e.b));
      chk({e.name, ".wb_pending"}, 32'(wb_pending), 32'(e.wbp));
      if (e.wbp) chk({e.name, ".wb_rd"}, 32'(wb_rd), 32'(e.rd));
      chk({e.name, ".jump_valid"}, 32'(jump_valid), 32'(e.jv));
      chk({e.name, ".jump_target"}, 32'(jump_target), 32'(e.jt));
      chk($sformatf("%s.dbg_R%0d", e.name, e.dba), 32'(dbg_data), 32'(e.dbg));
    end
  end

  task automatic step(input string name, input logic rst, input logic v, input logic [7:0] ins,
                      input logic [1:0] dba, input logic [7:0] ea, input logic [7:0] eb,
                      input logic ewp, input logic [1:0] erd, input logic ejv,
                      input logic [5:0] ejt, input logic [7:0] edbg);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    instr_valid = v;
    instr       = ins;
    dbg_addr    = dba;
    e.name = name; e.a = ea; e.b = eb; e.wbp = ewp; e.rd = erd;
    e.jv = ejv; e.jt = ejt; e.dba = dba; e.dbg = edbg;
    q.push_back(e);
  endtask

  localparam logic [7:0] NOP = 8'hC0;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = NOP; dbg_addr = 2'd0;
    // Reset: every register reads zero.
    for (int i = 0; i < 4; i++) begin
      step("rst", 1, 0, NOP, 2'(i), 0, 0, 0, 0, 0, 6'h00, 8'h00);
    end
    // LI R1,#5 then NOP.
    step("li1",    0, 1, 8'h55, 2'd1, 8'd5, 8'd0, 1, 2'd1, 0, 6'h00, 8'h00);
    step("li1_wb", 0, 1, NOP,   2'd1, 8'd0, 8'd0, 0, 2'd0, 0, 6'h00, 8'h05);
    // Back-to-back dependency with bypass on operand B.
    step("b2b_rst", 1, 0, NOP,  2'd1, 8'd0, 8'd0, 0, 2'd0, 0, 6'h00, 8'h00);
    step("b2b_li1", 0, 1, 8'h55, 2'd1, 8'd5, 8'd0, 1, 2'd1, 0, 6'h00, 8'h00);
    step("b2b_li2", 0, 1, 8'h69, 2'd1, 8'd9, 8'd0, 1, 2'd2, 0, 6'h00, 8'h05);
    step("b2b_add", 0, 1, 8'h18, 2'd2, 8'd5, 8'd9, 1, 2'd1, 0, 6'h00, 8'h09);
    step("b2b_wb",  0, 1, NOP,   2'd1, 8'd0, 8'd0, 0, 2'd0, 0, 6'h00, 8'h0E);
    // Wrap: LI R0,#15 then five ADD R0,R0 back-to-back.
    step("wr_li",  0, 1, 8'h4F, 2'd0, 8'd15,  8'd0,   1, 2'd0, 0, 6'h00, 8'h00);
    step("wr_ad1", 0, 1, 8'h00, 2'd0, 8'd15,  8'd15,  1, 2'd0, 0, 6'h00, 8'h0F);
    step("wr_ad2", 0, 1, 8'h00, 2'd0, 8'd30,  8'd30,  1, 2'd0, 0, 6'h00, 8'h1E);
    step("wr_ad3", 0, 1, 8'h00, 2'd0, 8'd60,  8'd60,  1, 2'd0, 0, 6'h00, 8'h3C);
    step("wr_ad4", 0, 1, 8'h00, 2'd0, 8'd120, 8'd120, 1, 2'd0, 0, 6'h00, 8'h78);
    step("wr_ad5", 0, 1, 8'h00, 2'd0, 8'd240, 8'd240, 1, 2'd0, 0, 6'h00, 8'hF0);
    step("wr_wb",  0, 1, NOP,   2'd0, 8'd0,   8'd0,   0, 2'd0, 0, 6'h00, 8'hE0);
    // JUMP 0x2A: single pulse, target held, registers unchanged.
    step("jmp",     0, 1, 8'hAA, 2'd0, 8'd0, 8'd0, 0, 2'd0, 1, 6'h2A, 8'hE0);
    step("jmp_nop", 0, 1, NOP,   2'd1, 8'd0, 8'd0, 0, 2'd0, 0, 6'h2A, 8'h0E);
    // instr_valid=0 with an LI on the bus behaves as NOP.
    step("inval",   0, 0, 8'h55, 2'd2, 8'd0, 8'd0, 0, 2'd0, 0, 6'h2A, 8'h09);
    step("inval2",  0, 1, NOP,   2'd1, 8'd0, 8'd0, 0, 2'd0, 0, 6'h2A, 8'h0E);
    // Reset right after LI R3,#7 discards the writeback and ignores instr_valid.
    step("rl_li",  0, 1, 8'h77, 2'd3, 8'd7, 8'd0, 1, 2'd3, 0, 6'h2A, 8'h00);
    step("rl_rst", 1, 1, 8'h55, 2'd3, 8'd0, 8'd0, 0, 2'd0, 0, 6'h00, 8'h00);
    step("rl_r3",  0, 1, NOP,   2'd3, 8'd0, 8'd0, 0, 2'd0, 0, 6'h00, 8'h00);
    step("rl_r1",  0, 1, NOP,   2'd1, 8'd0, 8'd0, 0, 2'd0, 0, 6'h00, 8'h00);
    // Let the monitor drain the last entry, bounded to a few cycles.
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_wb.md
Name: operand_fetch_wb

Overview:
- Decode/operand-fetch stage that drives the 8-bit execute adder's alu_input_a / alu_input_b. It also closes the loop by writing alu_out back into a 4-entry register file.
- Holds the architectural registers, decodes ADD / LI / JUMP / NOP, and registers operands one cycle ahead of the combinational execute stage.
- Bypasses alu_out to back-to-back dependent instructions.

Parameters:
DATA_W, 8, datapath and register width; must match the execute adder width.
REG_N, 4, number of registers; fixed by the 2-bit register fields.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
instr  input  8  instruction word: [7:6] opcode, [5:4] rd, [3:2] rs, [3:0] imm4, [5:0] target6.
instr_valid  input  1  instr is presented this cycle and is consumed at the next rising edge.
alu_out  input  DATA_W  combinational sum returned from the execute stage.
alu_input_a  output  DATA_W  registered operand A to the execute stage.
alu_input_b  output  DATA_W  registered operand B to the execute stage.
wb_pending  output  1  registered; alu_out will be written to wb_rd at the next edge.
wb_rd  output  2  registered destination of the pending writeback.
jump_valid  output  1  registered one-cycle pulse on JUMP.
jump_target  output  6  registered jump address; held until the next JUMP.
dbg_addr  input  2  debug read address.
dbg_data  output  DATA_W  combinational read of R[dbg_addr]; no bypass applied.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled at a rising edge while reset=1):
  - R0..R3 = 0; alu_input_a = alu_input_b = 0; wb_pending = 0; wb_rd = 0; jump_valid = 0; jump_target = 0.
  - A writeback pending at that edge is discarded.
  - reset overrides instr_valid.
- Opcodes, when instr_valid=1 at edge N:
  - 00 ADD: a <= src(rd), b <= src(rs), wb_pending <= 1, wb_rd <= rd.
  - 01 LI: a <= zero-extended imm4, b <= 0, wb_pending <= 1, wb_rd <= rd.
  - 10 JUMP: a <= 0, b <= 0, wb_pending <= 0, jump_valid <= 1, jump_target <= target6.
  - 11 NOP: a <= 0, b <= 0, wb_pending <= 0.
- When instr_valid=0: behaves as NOP.
- jump_valid is 0 on every edge that does not decode a JUMP.
- Writeback timing:
  - Execute is combinational, so alu_out is valid during cycle N+1.
  - At edge N+1, if wb_pending=1, R[wb_rd] <= alu_out. Writes are mod 2^DATA_W; carry out is ignored.
- Latency: instruction to operands = 1 cycle; instruction to register update = 2 edges.
- Bypass, src(x):
  - If wb_pending=1 and wb_rd==x, src(x) = alu_out; otherwise src(x) = R[x].
  - Applies to both operands independently, including rd==rs.
- Writeback and a new instruction may occur on the same edge:
  - The old destination is written with alu_out.
  - The new pipeline registers load using bypassed values.
  - A new instruction targeting the same register simply re-arms wb_pending.
- No stalls; one instruction per cycle is sustained. No other internal state exists.
- dbg_data reflects the register array only; a write becomes visible after its edge.

Test Plan:
- Reset, then dbg reads 0..3 -> all 0; alu_input_a = alu_input_b = 0; wb_pending = 0; jump_valid = 0.
- LI R1,#5 (0x55), then NOPs -> next cycle a=5, b=0, wb_pending=1, wb_rd=1; one edge later dbg R1 = 0x05, wb_pending=0.
- Back-to-back: LI R1,#5; LI R2,#9; ADD R1,R2 -> the ADD's operands are a=5, b=9 via R1 written and R2 bypassed; afterwards R1 = 0x0E.
- Wrap: LI R0,#15, then ADD R0,R0 repeated 4 times back-to-back -> R0 sequence 0x1E, 0x3C, 0x78, 0xF0; a fifth ADD R0,R0 -> R0 = 0xE0 (carry dropped).
- JUMP 0x2A (0xAA) -> jump_valid=1 for exactly 1 cycle, jump_target=0x2A held; no register changes; the following NOP keeps jump_valid=0.
- Reset asserted in the cycle after LI R3,#7 -> R3 stays 0, wb_pending=0; instr_valid during reset is ignored.
